// File: rtl/fetch_byte_queue_if.sv
// Fetch/decode side signals of the instruction byte queue.
// The master modport is the fetch unit plus decode; the slave modport is the queue.
interface fetch_byte_queue_if #(
  parameter int WINDOW_BYTES = 16
);
  logic                        fill_valid;
  logic                        fill_ready;
  logic [63:0]                 fill_data;
  logic                        redirect_valid;
  logic [63:0]                 redirect_pc;
  logic [0:WINDOW_BYTES*8-1]   win_bytes;
  logic [4:0]                  win_count;
  logic [63:0]                 win_pc;
  logic                        consume_valid;
  logic [4:0]                  consume_count;
  logic                        err;
  logic [31:0]                 stat_empty_cycles;
  logic [15:0]                 stat_redirects;

  modport master (
    output fill_valid, fill_data, redirect_valid, redirect_pc,
           consume_valid, consume_count,
    input  fill_ready, win_bytes, win_count, win_pc, err,
           stat_empty_cycles, stat_redirects
  );

  modport slave (
    input  fill_valid, fill_data, redirect_valid, redirect_pc,
           consume_valid, consume_count,
    output fill_ready, win_bytes, win_count, win_pc, err,
           stat_empty_cycles, stat_redirects
  );
endinterface

// File: rtl/fetch_byte_queue.sv
// Circular instruction byte queue presenting a decode window at the next undecoded byte.
// Define FETCH_QUEUE_STATS_EN to build the empty-cycle and redirect performance counters.
module fetch_byte_queue #(
  parameter int DEPTH_BYTES  = 32,
  parameter int FETCH_BYTES  = 8,
  parameter int WINDOW_BYTES = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  fetch_byte_queue_if.slave   q_if
);

  localparam int PW = $clog2(DEPTH_BYTES);
  localparam logic [PW:0] FILL_LIM = (PW+1)'(DEPTH_BYTES - FETCH_BYTES);
  localparam logic [PW:0] WIN_LIM  = (PW+1)'(WINDOW_BYTES);

  logic [7:0]    store_q [DEPTH_BYTES];
  logic [PW:0]   head_q, head_d;
  logic [PW:0]   tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic [2:0]    skip_q, skip_d;
  logic [63:0]   pc_q, pc_d;
  logic          err_q, err_d;

  logic          fill_fire;
  logic          cons_bad;
  logic          cons_ok;
  logic [PW:0]   win_cnt_full;
  logic [PW:0]   acc_n;
  logic [PW:0]   cons_n;
  logic [PW-1:0] wr_idx [FETCH_BYTES];
  logic          wr_en  [FETCH_BYTES];

  always_comb begin
    q_if.fill_ready = reset_n && !q_if.redirect_valid && (count_q <= FILL_LIM);
    fill_fire       = q_if.fill_valid && q_if.fill_ready;
    win_cnt_full    = (count_q > WIN_LIM) ? WIN_LIM : count_q;
    // A redirect discards any same-cycle consume, including a bad one.
    cons_bad = !q_if.redirect_valid && q_if.consume_valid &&
               ((q_if.consume_count == 5'd0) ||
                ((PW+1)'(q_if.consume_count) > win_cnt_full));
    cons_ok  = !q_if.redirect_valid && q_if.consume_valid && !cons_bad;
    acc_n    = fill_fire ? ((PW+1)'(FETCH_BYTES) - (PW+1)'(skip_q)) : '0;
    cons_n   = cons_ok ? (PW+1)'(q_if.consume_count) : '0;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    skip_d  = skip_q;
    pc_d    = pc_q;
    err_d   = err_q | cons_bad;
    if (q_if.redirect_valid) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = q_if.redirect_pc;
      skip_d  = q_if.redirect_pc[2:0];
    end else begin
      head_d  = head_q + cons_n;
      tail_d  = tail_q + acc_n;
      count_d = count_q - cons_n + acc_n;
      pc_d    = pc_q + 64'(cons_n);
      if (fill_fire) skip_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      skip_q  <= 3'd0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      skip_q  <= skip_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  // Leading bytes of a misaligned first beat are dropped; the rest pack at tail.
  always_comb begin
    for (int j = 0; j < FETCH_BYTES; j++) begin
      wr_idx[j] = tail_q[PW-1:0] + PW'(j) - PW'(skip_q);
      wr_en[j]  = fill_fire && (3'(j) >= skip_q);
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < FETCH_BYTES; j++) begin
      if (wr_en[j]) store_q[wr_idx[j]] <= q_if.fill_data[8*j +: 8];
    end
  end

  always_comb begin
    q_if.win_bytes = '0;
    for (int k = 0; k < WINDOW_BYTES; k++) begin
      if ((PW+1)'(k) < win_cnt_full)
        q_if.win_bytes[8*k +: 8] = store_q[head_q[PW-1:0] + PW'(k)];
    end
  end

  assign q_if.win_count = win_cnt_full[4:0];
  assign q_if.win_pc    = pc_q;
  assign q_if.err       = err_q;

`ifdef FETCH_QUEUE_STATS_EN
  logic [31:0] empty_cyc_q;
  logic [15:0] redirects_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      empty_cyc_q <= '0;
      redirects_q <= '0;
    end else begin
      if ((count_q == '0) && (empty_cyc_q != '1)) empty_cyc_q <= empty_cyc_q + 32'd1;
      if (q_if.redirect_valid && (redirects_q != '1)) redirects_q <= redirects_q + 16'd1;
    end
  end

  assign q_if.stat_empty_cycles = empty_cyc_q;
  assign q_if.stat_redirects    = redirects_q;
`else
  assign q_if.stat_empty_cycles = 32'd0;
  assign q_if.stat_redirects    = 16'd0;
`endif

endmodule
